// File: rtl/rv0_exu_sched_if.sv
// Scheduler-side bundle: IDU issue, IB input/output, MDU control and EXU result signals.
// Signal suffixes are from the scheduler's point of view.
interface rv0_exu_sched_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
);
    logic [31:0]      idu_insn_i;
    logic [XLEN-1:0]  idu_addr_i;
    logic             idu_rdy_i;
    logic             idu_ack_o;
    logic             ib_rdy_o;
    logic             ib_ack_i;
    logic             ib_out_rdy_i;
    logic [XLEN-1:0]  ib_out_wdata_i;
    logic [31:0]      ib_out_insn_i;
    logic [XLEN-1:0]  ib_out_addr_i;
    logic             ib_out_ack_o;
    logic             mdu_start_o;
    logic             mdu_abort_o;
    logic             mdu_done_i;
    logic [XLEN-1:0]  mdu_wdata_i;
    logic             kill_i;
    logic             exu_rdy_o;
    logic             exu_ack_i;
    logic [XLEN-1:0]  exu_wdata_o;
    logic [31:0]      exu_insn_o;
    logic [XLEN-1:0]  exu_addr_o;
    logic [CNT_W-1:0] mdu_cyc_o;

    modport slave (
        input  idu_insn_i, idu_addr_i, idu_rdy_i, ib_ack_i,
               ib_out_rdy_i, ib_out_wdata_i, ib_out_insn_i, ib_out_addr_i,
               mdu_done_i, mdu_wdata_i, kill_i, exu_ack_i,
        output idu_ack_o, ib_rdy_o, ib_out_ack_o, mdu_start_o, mdu_abort_o,
               exu_rdy_o, exu_wdata_o, exu_insn_o, exu_addr_o, mdu_cyc_o
    );

    modport master (
        output idu_insn_i, idu_addr_i, idu_rdy_i, ib_ack_i,
               ib_out_rdy_i, ib_out_wdata_i, ib_out_insn_i, ib_out_addr_i,
               mdu_done_i, mdu_wdata_i, kill_i, exu_ack_i,
        input  idu_ack_o, ib_rdy_o, ib_out_ack_o, mdu_start_o, mdu_abort_o,
               exu_rdy_o, exu_wdata_o, exu_insn_o, exu_addr_o, mdu_cyc_o
    );
endinterface

// File: rtl/rv0_exu_sched.sv
// Execute-stage issue scheduler: steers IDU instructions to IB or MDU, stalls
// while an MDU op is outstanding and merges results onto the EXU output in order.
module rv0_exu_sched #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic               clk_i,
    input logic               rst_ni,
    rv0_exu_sched_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e           state_q, state_d;
    logic [31:0]      insn_q, insn_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_mdu;
    logic idu_ack, ib_rdy, start, abort, exu_rdy, ib_out_ack;

    assign is_mdu = (bus.idu_insn_i[6:0] == 7'b0110011) && (bus.idu_insn_i[31:25] == 7'b0000001);

    always_comb begin
        state_d = state_q;
        insn_d  = insn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        idu_ack = 1'b0;
        ib_rdy  = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.idu_rdy_i && is_mdu) begin
                    idu_ack = 1'b1;
                    start   = 1'b1;
                    insn_d  = bus.idu_insn_i;
                    addr_d  = bus.idu_addr_i;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    ib_rdy  = bus.idu_rdy_i;
                    idu_ack = bus.ib_ack_i;
                end
            end
            BUSY: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                // Kill takes priority over a same-cycle done; the result is dropped.
                if (bus.kill_i) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (bus.mdu_done_i) begin
                    wdata_d = bus.mdu_wdata_i;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.kill_i) state_d = IDLE;
                else if (!bus.ib_out_rdy_i && bus.exu_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Any pending IB entry predates the MDU op, so it always drains first.
    always_comb begin
        if (bus.ib_out_rdy_i) begin
            exu_rdy         = 1'b1;
            ib_out_ack      = bus.exu_ack_i;
            bus.exu_wdata_o = bus.ib_out_wdata_i;
            bus.exu_insn_o  = bus.ib_out_insn_i;
            bus.exu_addr_o  = bus.ib_out_addr_i;
        end else begin
            exu_rdy         = (state_q == DONE);
            ib_out_ack      = 1'b0;
            bus.exu_wdata_o = wdata_q;
            bus.exu_insn_o  = insn_q;
            bus.exu_addr_o  = addr_q;
        end
    end

    // Handshake and pulse outputs are forced low for the whole reset window.
    assign bus.idu_ack_o    = rst_ni & idu_ack;
    assign bus.ib_rdy_o     = rst_ni & ib_rdy;
    assign bus.mdu_start_o  = rst_ni & start;
    assign bus.mdu_abort_o  = rst_ni & abort;
    assign bus.exu_rdy_o    = rst_ni & exu_rdy;
    assign bus.ib_out_ack_o = rst_ni & ib_out_ack;
    assign bus.mdu_cyc_o    = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            insn_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            insn_q  <= insn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_rv0_exu_sched.sv
// Directed bench for rv0_exu_sched: EXU results checked by a scoreboard monitor,
// control signals checked directly against hand-computed values.
module tb_rv0_exu_sched;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;
    localparam logic [31:0] ADD = 32'h0020_8033;
    localparam logic [31:0] MUL = 32'h0220_8033;

    typedef struct packed {
        logic [XLEN-1:0] wdata;
        logic [31:0]     insn;
        logic [XLEN-1:0] addr;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv0_exu_sched_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
    rv0_exu_sched #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    res_t exp_q[$];
    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        res_t e;
        if (rst_n && bus.exu_rdy_o && bus.exu_ack_i) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL exu_unexpected: got wdata 0x%0h with empty scoreboard", bus.exu_wdata_o);
            end else begin
                e = exp_q.pop_front();
                chk("exu_wdata", 64'(bus.exu_wdata_o), 64'(e.wdata));
                chk("exu_insn",  64'(bus.exu_insn_o),  64'(e.insn));
                chk("exu_addr",  64'(bus.exu_addr_o),  64'(e.addr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] insn, input logic [XLEN-1:0] addr);
        bus.idu_insn_i = insn;
        bus.idu_addr_i = addr;
        bus.idu_rdy_i  = 1'b1;
        bus.ib_ack_i   = 1'b1;
    endtask

    task automatic idle_idu();
        bus.idu_rdy_i = 1'b0;
        bus.ib_ack_i  = 1'b0;
    endtask

    function automatic logic [5:0] ctl();
        return {bus.idu_ack_o, bus.ib_rdy_o, bus.mdu_start_o, bus.mdu_abort_o,
                bus.exu_rdy_o, bus.ib_out_ack_o};
    endfunction

    initial begin
        bus.idu_insn_i = '0; bus.idu_addr_i = '0; bus.idu_rdy_i = 1'b0; bus.ib_ack_i = 1'b0;
        bus.ib_out_rdy_i = 1'b0; bus.ib_out_wdata_i = '0; bus.ib_out_insn_i = '0;
        bus.ib_out_addr_i = '0; bus.mdu_done_i = 1'b0; bus.mdu_wdata_i = '0;
        bus.kill_i = 1'b0; bus.exu_ack_i = 1'b0;

        // Reset state
        #3;
        chk("rst_ctl", 64'(ctl()), 64'h0);
        chk("rst_cyc", 64'(bus.mdu_cyc_o), 64'h0);
        chk("rst_wdata", 64'(bus.exu_wdata_o), 64'h0);
        tick(); tick();
        rst_n = 1'b1;

        // ADD passes straight through to IB, then IB result drains
        issue(ADD, 32'h100);
        @(negedge clk);
        chk("add_ack", 64'({bus.idu_ack_o, bus.ib_rdy_o, bus.mdu_start_o}), 64'b110);
        tick();
        idle_idu();
        bus.ib_out_rdy_i = 1'b1; bus.ib_out_wdata_i = 32'h11;
        bus.ib_out_insn_i = ADD; bus.ib_out_addr_i = 32'h100; bus.exu_ack_i = 1'b1;
        exp_q.push_back('{wdata: 32'h11, insn: ADD, addr: 32'h100});
        @(negedge clk);
        chk("ib_out_ack", 64'(bus.ib_out_ack_o), 64'h1);
        tick();
        bus.ib_out_rdy_i = 1'b0;

        // MUL: start pulse, stall, result one cycle after done, 1 bubble
        issue(MUL, 32'h104);
        exp_q.push_back('{wdata: 32'h30, insn: MUL, addr: 32'h104});
        @(negedge clk);
        chk("mul_issue", 64'({bus.idu_ack_o, bus.ib_rdy_o, bus.mdu_start_o}), 64'b101);
        tick();
        issue(ADD, 32'h108);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("mul_stall", 64'({bus.idu_ack_o, bus.ib_rdy_o, bus.mdu_start_o}), 64'b000);
            tick();
        end
        bus.mdu_done_i = 1'b1; bus.mdu_wdata_i = 32'h30;
        @(negedge clk);
        chk("mul_done_rdy", 64'(bus.exu_rdy_o), 64'h0);
        tick();
        bus.mdu_done_i = 1'b0;
        @(negedge clk);
        chk("mul_exu_rdy", 64'(bus.exu_rdy_o), 64'h1);
        chk("mul_cyc", 64'(bus.mdu_cyc_o), 64'd5);
        chk("mul_bubble", 64'(bus.idu_ack_o), 64'h0);
        tick();
        @(negedge clk);
        chk("mul_next_issue", 64'({bus.idu_ack_o, bus.ib_rdy_o}), 64'b11);
        tick();
        idle_idu();

        // IB result pending when MDU completes: IB drains first
        bus.exu_ack_i = 1'b0;
        issue(MUL, 32'h10c);
        bus.ib_out_rdy_i = 1'b1; bus.ib_out_wdata_i = 32'h22;
        bus.ib_out_insn_i = ADD; bus.ib_out_addr_i = 32'h108;
        exp_q.push_back('{wdata: 32'h22, insn: ADD, addr: 32'h108});
        exp_q.push_back('{wdata: 32'h44, insn: MUL, addr: 32'h10c});
        @(negedge clk);
        chk("ord_start", 64'(bus.mdu_start_o), 64'h1);
        tick();
        idle_idu();
        tick();
        bus.mdu_done_i = 1'b1; bus.mdu_wdata_i = 32'h44;
        tick();
        bus.mdu_done_i = 1'b0;
        @(negedge clk);
        chk("ord_ib_first", 64'(bus.exu_wdata_o), 64'h22);
        chk("ord_hold_ack", 64'(bus.ib_out_ack_o), 64'h0);
        tick();
        bus.exu_ack_i = 1'b1;
        @(negedge clk);
        chk("ord_ib_ack", 64'(bus.ib_out_ack_o), 64'h1);
        tick();
        bus.ib_out_rdy_i = 1'b0;
        @(negedge clk);
        chk("ord_mdu_rdy", 64'(bus.exu_rdy_o), 64'h1);
        tick();
        @(negedge clk);
        chk("ord_idle", 64'(bus.exu_rdy_o), 64'h0);
        tick();

        // Kill wins over simultaneous done
        issue(MUL, 32'h110);
        @(negedge clk);
        chk("kd_start", 64'(bus.mdu_start_o), 64'h1);
        tick();
        idle_idu();
        tick();
        bus.mdu_done_i = 1'b1; bus.kill_i = 1'b1; bus.mdu_wdata_i = 32'h99;
        @(negedge clk);
        chk("kd_abort", 64'({bus.mdu_abort_o, bus.mdu_start_o}), 64'b10);
        tick();
        bus.mdu_done_i = 1'b0; bus.kill_i = 1'b0;
        issue(ADD, 32'h114);
        @(negedge clk);
        chk("kd_no_result", 64'(bus.exu_rdy_o), 64'h0);
        chk("kd_next_issue", 64'({bus.idu_ack_o, bus.ib_rdy_o}), 64'b11);
        tick();
        idle_idu();

        // Counter saturation, then kill
        issue(MUL, 32'h118);
        @(negedge clk);
        chk("sat_start", 64'(bus.mdu_start_o), 64'h1);
        tick();
        idle_idu();
        repeat (70) tick();
        @(negedge clk);
        chk("sat_cyc", 64'(bus.mdu_cyc_o), 64'd63);
        tick();
        bus.kill_i = 1'b1;
        @(negedge clk);
        chk("sat_abort", 64'(bus.mdu_abort_o), 64'h1);
        tick();
        bus.kill_i = 1'b0;
        issue(ADD, 32'h11c);
        @(negedge clk);
        chk("sat_idle_issue", 64'(bus.idu_ack_o), 64'h1);
        chk("sat_cyc_hold", 64'(bus.mdu_cyc_o), 64'd63);
        tick();
        idle_idu();

        // Asynchronous reset while holding an unacked MDU result
        bus.exu_ack_i = 1'b0;
        issue(MUL, 32'h120);
        tick();
        idle_idu();
        bus.mdu_done_i = 1'b1; bus.mdu_wdata_i = 32'h55;
        tick();
        bus.mdu_done_i = 1'b0;
        @(negedge clk);
        chk("ar_done_rdy", 64'({bus.exu_rdy_o, bus.exu_wdata_o}), {1'b1, 32'h55});
        #1 rst_n = 1'b0;
        #1;
        chk("ar_ctl", 64'(ctl()), 64'h0);
        chk("ar_data", 64'({bus.exu_wdata_o, bus.mdu_cyc_o}), 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        issue(ADD, 32'h124);
        @(negedge clk);
        chk("ar_idle_issue", 64'({bus.idu_ack_o, bus.exu_rdy_o}), 64'b10);
        tick();
        idle_idu();

        chk("sb_empty", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
